// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared processor constants and fetch state encoding
// Contents: fetch_state_t (IDLE/RUN/HALTED), default PC width and start address
// shared by fetch, branch unit and instruction memory.
package proc_pkg;

  localparam int DEFAULT_PC_W       = 10;
  localparam int DEFAULT_START_ADDR = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter for profiling
// Ports: clk, rst_n (async active-low), clear (sync clear, wins over inc),
//        inc (count one), count (W-bit value, sticks at all-ones).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - program counter and fetch sequencing stage
// Ports: clk, reset (async active-low), start, stall, halt_instr, branch,
//        branch_addr -> pc, running, done, cycle_count, instr_count.
module fetch_pc_unit
  import proc_pkg::*;
#(
  parameter int PC_W       = DEFAULT_PC_W,
  parameter int START_ADDR = DEFAULT_START_ADDR,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt_instr,
  input  logic             branch,
  input  logic [PC_W-1:0]  branch_addr,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            cnt_clear;
  logic            cyc_inc;
  logic            ins_inc;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_clear = 1'b0;
    cyc_inc   = 1'b0;
    ins_inc   = 1'b0;
    unique case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d   = RUN;
          pc_d      = START_PC;
          cnt_clear = 1'b1;
        end
      end
      RUN: begin
        cyc_inc = 1'b1;
        if (stall) begin
          // Stall freezes everything but the cycle counter, so a pending
          // halt or branch is re-evaluated on the first unstalled cycle.
        end else if (halt_instr) begin
          // The halt instruction retires; pc keeps pointing at it.
          state_d = HALTED;
          ins_inc = 1'b1;
        end else begin
          ins_inc = 1'b1;
          pc_d    = branch ? branch_addr : pc_q + PC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clear (cnt_clear),
    .inc   (cyc_inc),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clear (cnt_clear),
    .inc   (ins_inc),
    .count (instr_count)
  );

  assign pc      = pc_q;
  assign running = (state_q == RUN);
  assign done    = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - scoreboard bench for fetch_pc_unit (two configurations)
module tb_fetch_pc_unit;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stall;
  logic       halt_instr;
  logic       branch;
  logic [9:0] branch_addr;

  logic [9:0]  pc0, pc1;
  logic        running0, running1, done0, done1;
  logic [15:0] cyc0, ins0;
  logic [3:0]  cyc1, ins1;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_pc_unit #(.PC_W(10), .START_ADDR(0), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .halt_instr(halt_instr), .branch(branch), .branch_addr(branch_addr),
    .pc(pc0), .running(running0), .done(done0),
    .cycle_count(cyc0), .instr_count(ins0)
  );

  fetch_pc_unit #(.PC_W(10), .START_ADDR(1022), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .halt_instr(halt_instr), .branch(branch), .branch_addr(branch_addr),
    .pc(pc1), .running(running1), .done(done1),
    .cycle_count(cyc1), .instr_count(ins1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int pc;
    int run;
    int dn;
    int cyc;
    int ins;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: state 0=idle, 1=run, 2=halted
  int m_st[2];
  int m_pc[2];
  int m_cy[2];
  int m_in[2];
  int m_start[2] = '{0, 1022};
  int m_cmax[2]  = '{65535, 15};

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_st[d] = 0;
      m_pc[d] = m_start[d];
      m_cy[d] = 0;
      m_in[d] = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (m_st[d] != 1) begin
        if (start) begin
          m_st[d] = 1;
          m_pc[d] = m_start[d];
          m_cy[d] = 0;
          m_in[d] = 0;
        end
      end else begin
        if (m_cy[d] < m_cmax[d]) m_cy[d] = m_cy[d] + 1;
        if (!stall) begin
          if (m_in[d] < m_cmax[d]) m_in[d] = m_in[d] + 1;
          if (halt_instr) m_st[d] = 2;
          else if (branch) m_pc[d] = int'(branch_addr);
          else m_pc[d] = (m_pc[d] + 1) % 1024;
        end
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      e.pc  = m_pc[d];
      e.run = (m_st[d] == 1) ? 1 : 0;
      e.dn  = (m_st[d] == 2) ? 1 : 0;
      e.cyc = m_cy[d];
      e.ins = m_in[d];
      sb_q.push_back(e);
    end
  endtask

  task automatic compare_outputs(input string tag);
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (sb_q.size() == 0) begin
        check_eq({tag, "_sb_empty"}, 0, 1);
      end else begin
        e = sb_q.pop_front();
        check_eq($sformatf("%s_d%0d_pc", tag, d),   d == 0 ? int'(pc0) : int'(pc1), e.pc);
        check_eq($sformatf("%s_d%0d_run", tag, d),  d == 0 ? int'(running0) : int'(running1), e.run);
        check_eq($sformatf("%s_d%0d_done", tag, d), d == 0 ? int'(done0) : int'(done1), e.dn);
        check_eq($sformatf("%s_d%0d_cyc", tag, d),  d == 0 ? int'(cyc0) : int'(cyc1), e.cyc);
        check_eq($sformatf("%s_d%0d_ins", tag, d),  d == 0 ? int'(ins0) : int'(ins1), e.ins);
      end
    end
  endtask

  // Drive current inputs across one rising edge and score the result.
  task automatic step(input string tag);
    model_edge();
    push_expected();
    @(posedge clk);
    #1;
    compare_outputs(tag);
  endtask

  task automatic set_in(input logic s, input logic st, input logic h,
                        input logic b, input int ba);
    start       = s;
    stall       = st;
    halt_instr  = h;
    branch      = b;
    branch_addr = 10'(ba);
  endtask

  int cyc_before;
  int wrap_exp[5] = '{1023, 0, 1, 2, 3};

  initial begin
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0);
    model_reset();
    #12;
    push_expected();
    compare_outputs("reset");
    reset = 1'b1;

    // Idle ignores branch
    set_in(0, 0, 0, 1, 77);
    step("idle_ign");

    // Start and five sequential fetches; u1 shows the wrap
    set_in(1, 0, 0, 0, 0);
    step("start");
    check_eq("start_pc", int'(pc0), 0);
    check_eq("start_pc_wrapcfg", int'(pc1), 1022);
    set_in(0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step("seq");
      check_eq($sformatf("seq_pc%0d", i), int'(pc0), i);
      check_eq($sformatf("wrap_pc%0d", i), int'(pc1), wrap_exp[i-1]);
    end
    check_eq("seq_cyc5", int'(cyc0), 5);
    check_eq("seq_ins5", int'(ins0), 5);

    // Halt, restart, branch at pc=3
    set_in(0, 0, 1, 0, 0);
    step("halt1");
    set_in(1, 0, 0, 0, 0);
    step("restart1");
    set_in(0, 0, 0, 0, 0);
    repeat (3) step("pre_br");
    set_in(0, 0, 0, 1, 156);
    step("br");
    check_eq("br_pc", int'(pc0), 156);
    check_eq("br_ins", int'(ins0), 4);
    set_in(0, 0, 0, 0, 0);
    step("br_next");
    check_eq("br_next_pc", int'(pc0), 157);

    // Stall at pc=7 with branch and halt pending
    set_in(0, 0, 0, 1, 7);
    step("to7");
    cyc_before = int'(cyc0);
    set_in(0, 1, 1, 1, 41);
    for (int i = 0; i < 3; i++) begin
      step("stall");
      check_eq("stall_pc", int'(pc0), 7);
    end
    check_eq("stall_cyc", int'(cyc0), cyc_before + 3);
    set_in(0, 0, 0, 1, 41);
    step("unstall");
    check_eq("unstall_pc", int'(pc0), 41);

    // Halt at pc=20, inputs ignored while halted, then restart
    set_in(0, 0, 0, 1, 20);
    step("to20");
    set_in(0, 0, 1, 0, 0);
    step("halt20");
    check_eq("halt_done", int'(done0), 1);
    check_eq("halt_pc", int'(pc0), 20);
    set_in(0, 1, 1, 1, 99);
    repeat (3) step("halted_hold");
    check_eq("halted_pc", int'(pc0), 20);
    set_in(1, 0, 0, 0, 0);
    step("restart2");
    check_eq("restart_done", int'(done0), 0);
    check_eq("restart_cyc", int'(cyc0), 0);

    // Saturation of the 4-bit counters
    set_in(0, 0, 0, 0, 0);
    repeat (20) step("sat");
    check_eq("sat_cyc", int'(cyc1), 15);
    check_eq("sat_ins", int'(ins1), 15);
    check_eq("nosat_cyc", int'(cyc0), 20);

    // Asynchronous reset mid-cycle
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    push_expected();
    compare_outputs("async_rst");
    check_eq("async_rst_pc", int'(pc1), 1022);
    #1;
    reset = 1'b1;
    set_in(0, 0, 0, 1, 5);
    repeat (2) step("post_rst_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
